// File: rtl/mbox_pkg.sv
// Shared constants and types for the mailbox-to-Avalon-MM bridge.
// CSR offsets, CMD/STATUS bit positions, FSM state encoding.
package mbox_pkg;

  localparam logic [1:0] OFF_CMD    = 2'd0;
  localparam logic [1:0] OFF_WDATA  = 2'd1;
  localparam logic [1:0] OFF_RDATA  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int CMD_WR    = 16;
  localparam int CMD_RD    = 17;
  localparam int CMD_INC   = 18;
  localparam int CMD_REUSE = 19;

  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_TMO    = 2;
  localparam int ST_BADCMD = 3;
  localparam int ST_OVR    = 4;
  localparam int ST_PERR   = 5;
  localparam int ST_PSEL   = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    DONE
  } t_mbox_state;

  localparam logic [63:0] TMO_PATTERN = 64'hDEAD_DEAD_DEAD_DEAD;

endpackage

// File: rtl/mbox_port_mux.sv
// Per-port strobe decode and response selection for the mailbox bridge.
// Out-of-range ports drive no strobe and report waitrequest high.
module mbox_port_mux #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int PSEL_W    = 2
) (
  input  logic [PSEL_W-1:0]           port,
  input  logic                        rd_en,
  input  logic                        wr_en,
  input  logic [NUM_PORTS-1:0]        waitrequest,
  input  logic [NUM_PORTS-1:0]        readdatavalid,
  input  logic [NUM_PORTS*DATA_W-1:0] readdata,
  output logic [NUM_PORTS-1:0]        avm_read,
  output logic [NUM_PORTS-1:0]        avm_write,
  output logic                        wreq_sel,
  output logic                        rdv_sel,
  output logic [DATA_W-1:0]           rdata_sel
);

  always_comb begin
    avm_read  = '0;
    avm_write = '0;
    wreq_sel  = 1'b1;
    rdv_sel   = 1'b0;
    rdata_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port == PSEL_W'(p)) begin
        avm_read[p]  = rd_en;
        avm_write[p] = wr_en;
        wreq_sel     = waitrequest[p];
        rdv_sel      = readdatavalid[p];
        rdata_sel    = readdata[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mbox_avmm_bridge.sv
// Indirect CSR mailbox driving NUM_PORTS Avalon-MM slaves with timeout.
// Optional MBOX_AUTOINC_EN: CMD bit 18 auto-increment, bit 19 address reuse.
module mbox_avmm_bridge #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PSEL_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        pClk,
  input  logic                        reset,
  input  logic                        csr_wr,
  input  logic                        csr_rd,
  input  logic [1:0]                  csr_addr,
  input  logic [63:0]                 csr_wdata,
  output logic [63:0]                 csr_rdata,
  output logic                        csr_rdata_valid,
  output logic [ADDR_W-1:0]           avm_address,
  output logic [DATA_W-1:0]           avm_writedata,
  output logic [NUM_PORTS-1:0]        avm_read,
  output logic [NUM_PORTS-1:0]        avm_write,
  input  logic [NUM_PORTS-1:0]        avm_waitrequest,
  input  logic [NUM_PORTS*DATA_W-1:0] avm_readdata,
  input  logic [NUM_PORTS-1:0]        avm_readdatavalid
);

  import mbox_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PSEL_W:0] NP = (PSEL_W + 1)'(NUM_PORTS);

  t_mbox_state state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [PSEL_W-1:0] psel_q;
  logic [PSEL_W-1:0] port_q;
  logic              op_rd;
  logic [63:0]       rdata_q;
  logic              done_f, tmo_f, bad_f, ovr_f, perr_f;

  logic cmd_wr, wd_wr, ps_wr, st_rd;
  logic cmd_ok, cmd_go, busy, port_ok;
  logic wreq_sel, rdv_sel;
  logic [DATA_W-1:0] rd_sel;
  logic launch, ack, got_rd, tmo_ev, perr_ev, bad_ev, ovr_ev;
  logic [63:0] status, rd_mux;
  logic unused_bits;

  assign cmd_wr  = csr_wr & (csr_addr == OFF_CMD);
  assign wd_wr   = csr_wr & (csr_addr == OFF_WDATA);
  assign ps_wr   = csr_wr & (csr_addr == OFF_STATUS);
  assign st_rd   = csr_rd & (csr_addr == OFF_STATUS);
  assign busy    = (state != IDLE);
  assign cmd_ok  = csr_wdata[CMD_WR] ^ csr_wdata[CMD_RD];
  assign cmd_go  = cmd_wr & cmd_ok & ~busy;
  assign port_ok = {1'b0, psel_q} < NP;
  assign unused_bits = ^csr_wdata;

  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;

  mbox_port_mux #(
    .NUM_PORTS (NUM_PORTS),
    .DATA_W    (DATA_W),
    .PSEL_W    (PSEL_W)
  ) u_mux (
    .port          (port_q),
    .rd_en         ((state == ISSUE) & op_rd),
    .wr_en         ((state == ISSUE) & ~op_rd),
    .waitrequest   (avm_waitrequest),
    .readdatavalid (avm_readdatavalid),
    .readdata      (avm_readdata),
    .avm_read      (avm_read),
    .avm_write     (avm_write),
    .wreq_sel      (wreq_sel),
    .rdv_sel       (rdv_sel),
    .rdata_sel     (rd_sel)
  );

  always_ff @(posedge pClk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    ack       = 1'b0;
    got_rd    = 1'b0;
    tmo_ev    = 1'b0;
    perr_ev   = 1'b0;
    bad_ev    = cmd_wr & ~busy & ~cmd_ok;
    ovr_ev    = (cmd_wr | wd_wr) & busy;
    unique case (state)
      IDLE: begin
        if (cmd_go) begin
          launch    = port_ok;
          perr_ev   = ~port_ok;
          state_nxt = port_ok ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (!wreq_sel) begin
          ack       = 1'b1;
          state_nxt = op_rd ? WAIT_RD : DONE;
        end else if (cnt == CNT_LAST) begin
          tmo_ev    = 1'b1;
          state_nxt = DONE;
        end
      end
      WAIT_RD: begin
        if (rdv_sel) begin
          got_rd    = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          tmo_ev    = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    status = '0;
    status[ST_BUSY]   = busy;
    status[ST_DONE]   = done_f;
    status[ST_TMO]    = tmo_f;
    status[ST_BADCMD] = bad_f;
    status[ST_OVR]    = ovr_f;
    status[ST_PERR]   = perr_f;
    status[ST_PSEL +: PSEL_W] = psel_q;
  end

  always_comb begin
    rd_mux = '0;
    unique case (csr_addr)
      OFF_CMD:   rd_mux = 64'(addr_q);
      OFF_WDATA: rd_mux = 64'(wdata_q);
      OFF_RDATA: rd_mux = rdata_q;
      default:   rd_mux = status;
    endcase
  end

`ifdef MBOX_AUTOINC_EN
  logic inc_q;
  logic done_ev;
  assign done_ev = (ack & ~op_rd) | got_rd;
`endif

  always_ff @(posedge pClk or posedge reset) begin
    if (reset) begin
      cnt             <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      psel_q          <= '0;
      port_q          <= '0;
      op_rd           <= 1'b0;
      rdata_q         <= '0;
      done_f          <= 1'b0;
      tmo_f           <= 1'b0;
      bad_f           <= 1'b0;
      ovr_f           <= 1'b0;
      perr_f          <= 1'b0;
      csr_rdata       <= '0;
      csr_rdata_valid <= 1'b0;
`ifdef MBOX_AUTOINC_EN
      inc_q           <= 1'b0;
`endif
    end else begin
      if (ps_wr)          psel_q  <= csr_wdata[PSEL_W-1:0];
      if (wd_wr && !busy) wdata_q <= csr_wdata[DATA_W-1:0];
      if (cmd_go) begin
        op_rd  <= csr_wdata[CMD_RD];
        port_q <= psel_q;
`ifdef MBOX_AUTOINC_EN
        inc_q  <= csr_wdata[CMD_INC];
        if (!csr_wdata[CMD_REUSE]) addr_q <= csr_wdata[ADDR_W-1:0];
      end else if (done_ev && inc_q) begin
        addr_q <= addr_q + 1'b1;
`else
        addr_q <= csr_wdata[ADDR_W-1:0];
`endif
      end
      if (launch) cnt <= '0;
      else if (state == ISSUE || state == WAIT_RD) cnt <= cnt + 1'b1;
      if (got_rd)      rdata_q <= 64'(rd_sel);
      else if (tmo_ev) rdata_q <= TMO_PATTERN;
      // set events win over the clear-on-read of STATUS
      done_f <= (state == DONE) | (done_f & ~st_rd);
      tmo_f  <= tmo_ev  | (tmo_f  & ~st_rd);
      bad_f  <= bad_ev  | (bad_f  & ~st_rd);
      ovr_f  <= ovr_ev  | (ovr_f  & ~st_rd);
      perr_f <= perr_ev | (perr_f & ~st_rd);
      csr_rdata_valid <= csr_rd;
      if (csr_rd) csr_rdata <= rd_mux;
    end
  end

endmodule

// File: doc/mbox_avmm_bridge.md
Name: mbox_avmm_bridge

Overview:
- Parametrised indirect register-access bridge between the AFU MMIO CSR decoder and NUM_PORTS Avalon-MM MAC/PHY CSR slaves.
- Successor to the single-channel command/wdata/rdata mailbox; adds:
  - per-port select with range check
  - wait and read-data timeout
  - sticky error status
  - busy/overrun protection
  - configurable address and data widths
- Sits between the CCI-P MMIO register file and the per-port Ethernet MAC CSR interfaces.

Parameters:
NUM_PORTS, 4, number of Avalon-MM slave ports (1..16)
ADDR_W, 16, Avalon word-address width
DATA_W, 32, Avalon data width (32 or 64)
TIMEOUT_CYCLES, 1024, cycles allowed from issue to waitrequest-low (write) or readdatavalid (read)
PSEL_W, $clog2(NUM_PORTS) min 1, port-select width

Ports:
pClk  in  1  clock
reset  in  1  asynchronous active-high reset
csr_wr  in  1  CSR write strobe
csr_rd  in  1  CSR read strobe
csr_addr  in  2  0=CMD, 1=WDATA, 2=RDATA, 3=STATUS/PSEL
csr_wdata  in  64  CSR write data
csr_rdata  out  64  CSR read data
csr_rdata_valid  out  1  CSR read response strobe
avm_address  out  ADDR_W  shared slave address
avm_writedata  out  DATA_W  shared write data
avm_read  out  NUM_PORTS  one-hot read request
avm_write  out  NUM_PORTS  one-hot write request
avm_waitrequest  in  NUM_PORTS  per-port waitrequest
avm_readdata  in  NUM_PORTS*DATA_W  per-port read data, port p at [p*DATA_W +: DATA_W]
avm_readdatavalid  in  NUM_PORTS  per-port read data valid

Behaviour:
- Clock and reset: one clock, pClk. Reset is asynchronous, active-high. All outputs and registers clear to 0 on reset, including psel, rdata and status.
- CMD register:
  - Bit 16 = write, bit 17 = read, bits[ADDR_W-1:0] = address.
  - Write with exactly one of bits 16/17 set, while IDLE, latches address and launches the access.
  - Both set, or neither set: no access; sets sticky BADCMD.
- WDATA register: write latches csr_wdata[DATA_W-1:0]. Write while busy is dropped and sets OVR.
- PSEL: write to offset 3 latches csr_wdata[PSEL_W-1:0] as the port select.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
  - IDLE -> ISSUE on a valid CMD write. Launching a command with psel >= NUM_PORTS goes straight to DONE with ERR_PORT set; no Avalon strobe is asserted.
  - ISSUE: avm_read/avm_write[psel] held high until avm_waitrequest[psel]==0.
    - Write: -> DONE.
    - Read: -> WAIT_RD.
  - WAIT_RD: -> DONE on avm_readdatavalid[psel]; capture readdata into RDATA, zero-extended to 64.
  - DONE -> IDLE next cycle.
- Timeout:
  - Counter resets to 0 on entering ISSUE and counts in ISSUE and WAIT_RD.
  - When it reaches TIMEOUT_CYCLES-1: drop the strobe, set sticky TMO, load RDATA=64'hDEAD_DEAD_DEAD_DEAD, go to DONE.
- readdatavalid on a non-selected port, or outside WAIT_RD, is ignored.
- CMD write while not IDLE is dropped and sets sticky OVR; the in-flight access is unaffected.
- CSR read: csr_rdata_valid exactly 1 cycle after csr_rd, with the data sampled at csr_rd.
  - STATUS layout: bit0 busy (state!=IDLE), bit1 done-since-last-status-read, bit2 TMO, bit3 BADCMD, bit4 OVR, bit5 ERR_PORT, bits[11:8] psel.
  - Reading STATUS clears bits 1-5. An error event in the same cycle as the read wins: the bit stays set.
- Simultaneous csr_wr and csr_rd to different offsets: both are honoured.
- Reset mid-access: strobes drop asynchronously; no completion is reported.

Optional Feature:
- Macro: MBOX_AUTOINC_EN.
- Defined:
  - CMD bit 18 = auto-increment.
  - Each completed access without timeout adds 1 to the stored address (wraps at 2^ADDR_W).
  - CMD bit 19 = reuse: launches the access at the stored address, ignoring the CMD address field.
  - Purpose: consecutive stat-counter lo/hi reads.
- Undefined: bits 18/19 are ignored and the address is always taken from CMD.

Decomposition:
- Package mbox_pkg holds:
  - CSR offset constants and CMD bit positions (WR=16, RD=17, INC=18, REUSE=19)
  - STATUS bit positions
  - t_mbox_state enum
  - TMO_PATTERN constant
- Sub-module mbox_port_mux (combinational/registered per-port select):
  - one-hot strobe decode
  - waitrequest/readdatavalid/readdata selection by psel

Test Plan:
- Port 2 write: PSEL=2, WDATA=32'hDAEFCAFE, CMD=0x10000|0x0010 -> avm_write[2] pulses with address 0x0010 and writedata DAEFCAFE; STATUS=0x202 (done, psel=2).
- Port 2 read: slave on port 2 asserts waitrequest for 3 cycles and readdatavalid 5 cycles after acceptance with 32'h12345678; CMD=0x20010 -> RDATA=0x12345678, STATUS bit1 set.
- Timeout: port 1 holds waitrequest high; CMD=0x20000 -> after TIMEOUT_CYCLES, avm_read[1] drops, RDATA=DEADDEADDEADDEAD, STATUS bit2 set; the next STATUS read shows bit2 clear.
- Bad command and overrun: CMD=0x30000 -> no strobe, BADCMD set. Launch a read to a slave with long readdata latency, then a second CMD -> OVR set, and the first read still completes with the correct data.
- Port range: NUM_PORTS=3, PSEL=3, CMD=0x20000 -> no strobe, ERR_PORT set, busy clears within 2 cycles.
- MBOX_AUTOINC_EN: CMD=0x60C02 (RD|INC, addr 0xC02) then CMD=0xE0000 (RD|INC|REUSE) -> accesses at 0xC02 then 0xC03; stored address ends at 0xC04.
